add_pipe: RTL and testbench
===========================

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter STAGE_W, default 4, bits added per pipeline stage; WIDTH SHALL be a positive multiple of STAGE_W, and STAGES = WIDTH/STAGE_W.
REQ-003 Port clk, input, 1, single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, operand triple presented.
REQ-006 Port in_ready, output, 1, block accepts the operands this cycle.
REQ-007 Port ina, input, WIDTH, operand A.
REQ-008 Port inb, input, WIDTH, operand B.
REQ-009 Port cin, input, 1, carry-in.
REQ-010 Port out_valid, output, 1, result valid.
REQ-011 Port out_ready, input, 1, consumer accepts the result.
REQ-012 Port sum, output, WIDTH, (ina+inb+cin) mod 2^WIDTH.
REQ-013 Port cout, output, 1, carry out of bit WIDTH-1.
REQ-014 Port ovf, output, 1, two's-complement signed overflow: operand MSBs equal and sum MSB different.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 Stage i (0..STAGES-1) SHALL add bits [i*STAGE_W +: STAGE_W] of A and B plus the carry from stage i-1 (cin for stage 0), registering the partial sum, the carry and the not-yet-added operand bits.
REQ-017 Latency SHALL be exactly STAGES rising edges: an operation accepted on edge t SHALL produce out_valid=1 with its result after edge t+STAGES-1.
REQ-018 Throughput SHALL be one operation per cycle when out_ready=1; results SHALL leave in acceptance order.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational); when advance=0, every stage register including out_valid, sum, cout, ovf SHALL hold.
REQ-020 When advance=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-021 sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 A carry SHALL propagate correctly across all stage boundaries, including a full ripple from bit 0 to bit WIDTH-1.
REQ-023 STAGES=1 SHALL be legal: single registered adder, latency 1.
REQ-024 sum/cout/ovf SHALL be don't-care while out_valid=0; out_valid SHALL never assert for a bubble.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear every stage valid bit, out_valid, sum, cout and ovf to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after reset release.
REQ-027 in_ready SHALL be 1 during and immediately after reset (pipeline empty).

Structure
REQ-028 Shared package add_pkg SHALL hold default WIDTH and STAGE_W constants.
REQ-029 One sub-module add_chunk (STAGE_W-bit combinational adder: a, b, ci -> s, co) SHALL be instantiated once per stage.
REQ-030 Parameter legality (WIDTH mod STAGE_W = 0) SHALL be checked at elaboration.

Verification
REQ-031 WIDTH=16, STAGE_W=4, out_ready=1: ina=0x0001, inb=0x0001, cin=1 -> after 4 edges sum=0x0003, cout=0, ovf=0.
REQ-032 Full ripple: ina=0xFFFF, inb=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; then ina=0x7FFF, inb=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Back-to-back: 8 operations on consecutive cycles (0x0101+0x0010*k, k=0..7) -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
REQ-034 Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs frozen, no loss or duplication once out_ready=1.
REQ-035 Reset mid-stream: rst_n low for 1 cycle with 3 operations in flight -> out_valid=0 immediately, no stale result after release.
REQ-036 WIDTH=4, STAGE_W=4: ina=1011, inb=1001, cin=1 -> after 1 edge sum=0101, cout=1, ovf=1; ina=1010, inb=1010, cin=1 -> sum=0101, cout=1, ovf=1.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared defaults for the pipelined adder.
package add_pkg;

  localparam int ADD_WIDTH   = 16;
  localparam int ADD_STAGE_W = 4;

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - W-bit combinational adder slice with carry in/out.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s     = total[W-1:0];
  assign co    = total[W];

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - carry-pipelined adder, STAGE_W bits per stage, global stall on backpressure.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH   = ADD_WIDTH,
  parameter int STAGE_W = ADD_STAGE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / STAGE_W;
  localparam int LAST   = STAGES - 1;

  if (STAGE_W <= 0 || WIDTH <= 0 || (WIDTH % STAGE_W) != 0) begin : g_bad_params
    $error("add_pipe: WIDTH must be a positive multiple of STAGE_W");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  logic [STAGE_W-1:0] chunk_s  [STAGES];
  logic               chunk_co [STAGES];
  logic               advance;

  // Stage 0 adds straight from the ports; later stages add the slice carried in the previous register.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [STAGE_W-1:0] ca, cb;
    logic               cci;
    if (g == 0) begin : g_first
      assign ca  = ina[0 +: STAGE_W];
      assign cb  = inb[0 +: STAGE_W];
      assign cci = cin;
    end else begin : g_next
      assign ca  = a_q[g-1][g*STAGE_W +: STAGE_W];
      assign cb  = b_q[g-1][g*STAGE_W +: STAGE_W];
      assign cci = carry_q[g-1];
    end
    add_chunk #(.W(STAGE_W)) u_chunk (
      .a  (ca),
      .b  (cb),
      .ci (cci),
      .s  (chunk_s[g]),
      .co (chunk_co[g])
    );
  end

  always_comb begin
    advance = !valid_q[LAST] || out_ready;
    valid_d = valid_q;
    carry_d = carry_q;
    for (int i = 0; i < STAGES; i++) begin
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      sum_d[i] = sum_q[i];
    end
    if (advance) begin
      valid_d[0]                = in_valid;
      a_d[0]                    = ina;
      b_d[0]                    = inb;
      sum_d[0]                  = '0;
      sum_d[0][0 +: STAGE_W]    = chunk_s[0];
      carry_d[0]                = chunk_co[0];
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i]                   = valid_q[i-1];
        a_d[i]                       = a_q[i-1];
        b_d[i]                       = b_q[i-1];
        sum_d[i]                     = sum_q[i-1];
        sum_d[i][i*STAGE_W +: STAGE_W] = chunk_s[i];
        carry_d[i]                   = chunk_co[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        sum_q[i] <= sum_d[i];
      end
    end
  end

  // Overflow derives from the last stage's registered operands, so it holds whenever they do.
  assign in_ready  = advance;
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - randomized and directed self-checking bench for add_pipe.
module tb_add_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [15:0] ina = '0, inb = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  logic        s_in_valid = 1'b0, s_cin = 1'b0;
  logic [3:0]  s_ina = '0, s_inb = '0;
  logic        s_in_ready, s_out_valid, s_cout, s_ovf;
  logic [3:0]  s_sum;

  int n_chk = 0, n_pass = 0, n_in = 0, n_out = 0;
  res_t exp_q[$];
  logic prev_stall = 1'b0;
  logic [17:0] prev_out;

  always #5 clk = ~clk;

  add_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  add_pipe #(.WIDTH(4), .STAGE_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ina(s_ina), .inb(s_inb), .cin(s_cin), .out_valid(s_out_valid), .out_ready(1'b1),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  function automatic res_t model(logic [15:0] a, logic [15:0] b, logic c);
    res_t r;
    int unsigned t;
    t   = int'(a) + int'(b) + int'(c);
    r.s = t[15:0];
    r.c = t[16];
    r.o = (a[15] == b[15]) && (r.s[15] != a[15]);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted operation must emerge once, in order, with the arithmetic result.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({sum, cout, ovf}), 32'(prev_out));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          chk("out_result", 32'({sum, cout, ovf}), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {sum, cout, ovf};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ina, inb, cin));
        n_in++;
      end
    end
  end

  task automatic send_wait(logic [15:0] a, logic [15:0] b, logic c, output int edges);
    ina = a; inb = b; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, run, maxrun, nval;
    logic [4:0] t4;
    logic [3:0] ra, rb;
    logic rc;

    step();
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout_ovf", 32'({cout, ovf}), 32'd0);
    step();
    rst_n = 1'b1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    send_wait(16'h0001, 16'h0001, 1'b1, edges);
    chk("lat_basic", 32'(edges), 32'd4);
    chk("basic_result", 32'({sum, cout, ovf}), 32'({16'h0003, 1'b0, 1'b0}));
    step();
    send_wait(16'hFFFF, 16'h0000, 1'b1, edges);
    chk("ripple_result", 32'({sum, cout, ovf}), 32'({16'h0000, 1'b1, 1'b0}));
    step();
    send_wait(16'h7FFF, 16'h0001, 1'b0, edges);
    chk("ovf_result", 32'({sum, cout, ovf}), 32'({16'h8000, 1'b0, 1'b1}));
    step();
    chk("model_pin_a", 32'(model(16'h8000, 16'h8000, 1'b0)), 32'({16'h0000, 1'b1, 1'b1}));

    // Eight back-to-back operations; valid cycles must form one unbroken run.
    run = 0; maxrun = 0; nval = 0;
    for (int k = 0; k < 8; k++) begin
      ina = 16'h0101 + 16'(16 * k); inb = 16'(k); cin = k[0]; in_valid = 1'b1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin nval++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin nval++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      step();
    end
    chk("b2b_count", 32'(nval), 32'd8);
    chk("b2b_run", 32'(maxrun), 32'd8);

    // Fill under backpressure, hold five cycles, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ina = 16'($urandom); inb = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      step();
    end
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      ina = 16'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("bp_drain", 32'(n_out), 32'(n_in));

    // Reset with operations in flight.
    for (int k = 0; k < 4; k++) begin
      ina = 16'($urandom); inb = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) nval++;
      step();
    end
    chk("no_stale_after_rst", 32'(nval), 32'd0);

    // Random traffic with random backpressure.
    n_in = 0; n_out = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      case ($urandom % 5)
        0: begin ina = 16'hFFFF; inb = 16'($urandom % 2); end
        1: begin ina = 16'h7FFF; inb = 16'h8000 | 16'($urandom); end
        default: begin ina = 16'($urandom); inb = 16'($urandom); end
      endcase
      cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("rand_drain_count", 32'(n_out), 32'(n_in));
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single-stage instance: latency one edge.
    s_ina = 4'b1011; s_inb = 4'b1001; s_cin = 1'b1; s_in_valid = 1'b1;
    step();
    chk("w4_a_valid", 32'(s_out_valid), 32'd1);
    chk("w4_a_result", 32'({s_sum, s_cout, s_ovf}), 32'({4'b0101, 1'b1, 1'b1}));
    s_ina = 4'b1010; s_inb = 4'b1010; s_cin = 1'b1;
    step();
    chk("w4_b_result", 32'({s_sum, s_cout, s_ovf}), 32'({4'b0101, 1'b1, 1'b1}));
    for (int k = 0; k < 20; k++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      s_ina = ra; s_inb = rb; s_cin = rc;
      step();
      t4 = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      chk("w4_rand", 32'({s_out_valid, s_sum, s_cout, s_ovf}),
          32'({1'b1, t4[3:0], t4[4], (ra[3] == rb[3]) && (t4[3] != ra[3])}));
    end
    s_in_valid = 1'b0;
    step();
    chk("w4_bubble", 32'(s_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
